outport_serializer: RTL and testbench



---
 rtl/outport_serializer_pkg.sv | 10 +
 rtl/outport_serializer_sync_fifo.sv | 50 +++++
 rtl/outport_serializer.sv | 125 ++++++++++++
 tb/tb_outport_serializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/outport_serializer_pkg.sv
// outport_serializer_pkg: shared FSM state type and serial frame levels.
package outport_serializer_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/outport_serializer_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q  <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/outport_serializer.sv
// outport_serializer: buffers output-port writes and sends each word as a start/data/stop frame, LSB first.
module outport_serializer
    import outport_serializer_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              tx,
    output logic              tx_busy,
    output logic              overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state_q;
    logic [BW-1:0]     baud_q;
    logic [IW-1:0]     idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              tx_q;
    logic              busy_q;
    logic              ovf_q;
    logic [DATA_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              baud_end;
    logic              last_bit;
    logic              pop_d;

    assign baud_end = baud_q == BW'(CLKS_PER_BIT - 1);
    assign last_bit = idx_q == IW'(DATA_W - 1);
    // A new word is taken either from idle or at the very end of a stop bit, so frames run back to back.
    assign pop_d    = !fifo_empty && (state_q == IDLE || (state_q == STOP && baud_end));

    assign full     = fifo_full;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign overflow = ovf_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (pop_d),
        .din   (wr_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) assert (fifo_count <= CW'(DEPTH) && fifo_full == (fifo_count == CW'(DEPTH)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en && fifo_full) ovf_q <= 1'b1;
            baud_q <= (state_q == IDLE || baud_end) ? '0 : baud_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (pop_d) begin
                        state_q <= START;
                        shift_q <= fifo_dout;
                        tx_q    <= START_BIT;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_end) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (last_bit) begin
                            state_q <= STOP;
                            tx_q    <= STOP_BIT;
                        end else begin
                            shift_q <= shift_q >> 1;
                            idx_q   <= idx_q + 1'b1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        if (pop_d) begin
                            state_q <= START;
                            shift_q <= fifo_dout;
                            tx_q    <= START_BIT;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= IDLE_LEVEL;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outport_serializer.sv
// tb_outport_serializer: directed steps with a scoreboard of words checked by a serial-line receiver.
module tb_outport_serializer;

    localparam int C  = 4;
    localparam int FR = 34 * C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic        tx;
    logic        tx_busy;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    logic [31:0] sb[$];

    logic        rx_on = 1'b0;
    int          rx_p = 0;
    int          rx_done = 0;
    int          last_end = 0;
    logic [31:0] rx_word = '0;

    outport_serializer #(
        .DATA_W       (32),
        .DEPTH        (4),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upto(input int k);
        while (cyc < t0 + k) tick();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int b = 0;
        while (rx_done < n && b < budget) begin
            tick();
            b++;
        end
        chk("rx_count", rx_done, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Receiver: decodes every frame off the wire and compares it against the scoreboard head.
    always @(negedge clk) begin
        int slot;
        int off;
        logic [31:0] exp;
        if (reset) rx_on = 1'b0;
        else if (!rx_on) begin
            if (tx === 1'b0) begin
                rx_on = 1'b1;
                rx_p  = 0;
            end
        end else rx_p++;
        if (rx_on && !reset) begin
            slot = rx_p / C;
            off  = rx_p % C;
            chk("rx_busy", tx_busy, 1);
            if (slot == 0) chk("rx_start", tx, 0);
            else if (slot <= 32) begin
                if (off == 0) rx_word[slot-1] = tx;
                else chk("rx_bit_stable", tx, rx_word[slot-1]);
            end else chk("rx_stop", tx, 1);
            if (rx_p == FR - 1) begin
                exp = (sb.size() > 0) ? sb.pop_front() : 'x;
                chk("rx_word", rx_word, exp);
                rx_on = 1'b0;
                rx_done++;
                last_end = cyc;
            end
        end
    end

    initial begin
        int n;
        // Reset
        tick();
        do_reset();
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);

        // Single frame with explicit wire timing
        n = rx_done + 1;
        wr_en = 1'b1; wr_data = 32'hA5A5_0001; sb.push_back(32'hA5A5_0001);
        tick(); t0 = cyc; wr_en = 1'b0;
        upto(1);   chk("sf_c1_tx", tx, 0); chk("sf_c1_busy", tx_busy, 1);
        upto(4);   chk("sf_c4_tx", tx, 0);
        upto(5);   chk("sf_bit0", tx, 1);
        upto(9);   chk("sf_bit1", tx, 0);
        upto(129); chk("sf_bit31", tx, 1);
        upto(133); chk("sf_stop", tx, 1);
        upto(136); chk("sf_busy136", tx_busy, 1);
        upto(137); chk("sf_busy137", tx_busy, 0); chk("sf_idle_tx", tx, 1);
        wait_rx(n, 50);

        // Fill and overflow, then back-to-back frames
        n = rx_done + 5;
        wr_en = 1'b1;
        wr_data = 32'h1; sb.push_back(32'h1); tick(); t0 = cyc;
        wr_data = 32'h2; sb.push_back(32'h2); tick();
        wr_data = 32'h3; sb.push_back(32'h3); tick();
        chk("fo_full_c2", full, 0);
        wr_data = 32'h4; sb.push_back(32'h4); tick();
        chk("fo_full_c3", full, 0);
        wr_data = 32'h5; sb.push_back(32'h5); tick();
        chk("fo_full_c4", full, 1); chk("fo_ovf_c4", overflow, 0);
        wr_data = 32'h6; tick();
        wr_en = 1'b0;
        chk("fo_ovf_c5", overflow, 1); chk("fo_full_c5", full, 1);
        wait_rx(n, 5 * FR + 50);
        chk("fo_contig_end", last_end, t0 + 5 * FR);
        upto(5 * FR + 1); chk("fo_busy_end", tx_busy, 0); chk("fo_ovf_sticky", overflow, 1);

        // Write during final STOP cycle with FIFO full
        do_reset();
        n = rx_done + 5;
        wr_en = 1'b1;
        wr_data = 32'hA; sb.push_back(32'hA); tick(); t0 = cyc;
        wr_data = 32'hB; sb.push_back(32'hB); tick();
        wr_data = 32'hC; sb.push_back(32'hC); tick();
        wr_data = 32'hD; sb.push_back(32'hD); tick();
        wr_data = 32'hE; sb.push_back(32'hE); tick();
        wr_en = 1'b0;
        upto(136); chk("ws_full_pre", full, 1); chk("ws_ovf_pre", overflow, 0);
        wr_en = 1'b1; wr_data = 32'hF; tick(); wr_en = 1'b0;
        chk("ws_ovf", overflow, 1); chk("ws_full_fall", full, 0);
        chk("ws_next_start", tx, 0); chk("ws_busy", tx_busy, 1);
        wait_rx(n, 5 * FR + 50);
        chk("ws_busy_end", tx_busy, 0);

        // Reset mid-frame
        wr_en = 1'b1;
        wr_data = 32'h111; sb.push_back(32'h111); tick(); t0 = cyc;
        wr_data = 32'h222; sb.push_back(32'h222); tick();
        wr_data = 32'h333; sb.push_back(32'h333); tick();
        wr_en = 1'b0;
        upto(49); chk("rm_ovf_pre", overflow, 1); chk("rm_busy_pre", tx_busy, 1);
        reset = 1'b1; sb.delete(); tick();
        chk("rm_tx", tx, 1); chk("rm_busy", tx_busy, 0);
        chk("rm_ovf", overflow, 0); chk("rm_full", full, 0);
        chk("rm_count", dut.fifo_count, 0);
        reset = 1'b0; tick(); tick();
        chk("rm_quiet_tx", tx, 1); chk("rm_quiet_busy", tx_busy, 0);
        n = rx_done + 1;
        wr_en = 1'b1; wr_data = 32'h1357_9BDF; sb.push_back(32'h1357_9BDF); tick(); wr_en = 1'b0;
        wait_rx(n, FR + 50);

        // Push and pop on the same edge with two words queued
        n = rx_done + 4;
        wr_en = 1'b1;
        wr_data = 32'hCAFE_0001; sb.push_back(32'hCAFE_0001); tick(); t0 = cyc;
        wr_data = 32'hCAFE_0002; sb.push_back(32'hCAFE_0002); tick();
        wr_data = 32'hCAFE_0003; sb.push_back(32'hCAFE_0003); tick();
        wr_en = 1'b0;
        upto(136); chk("pp_count_pre", dut.fifo_count, 2);
        wr_en = 1'b1; wr_data = 32'hCAFE_0004; sb.push_back(32'hCAFE_0004); tick(); wr_en = 1'b0;
        chk("pp_count", dut.fifo_count, 2); chk("pp_full", full, 0);
        chk("pp_ovf", overflow, 0); chk("pp_start", tx, 0);
        wait_rx(n, 4 * FR + 50);
        chk("pp_busy_end", tx_busy, 0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
